// File: rtl/bus_master_arbiter_pkg.sv
// bus_master_arbiter_pkg
// Shared definitions for the external bus master arbiter:
//   - arb_state_e : arbiter FSM state encoding
//   - MAX_MASTERS : largest supported number of requesters
//   - idx_width() : width of a master index for a given master count
package bus_master_arbiter_pkg;

  localparam int unsigned MAX_MASTERS = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRequest = 2'd1,
    StGranted = 2'd2,
    StRelease = 2'd3
  } arb_state_e;

  // At least one bit so a single-master build still has a legal index vector.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker
// Combinational round-robin search. Starting just above last_i and ascending
// with wrap-around, returns the first index whose request bit is set.
// Ports:
//   req_i   : request vector (already masked by the caller)
//   last_i  : index of the previous winner (lowest priority this round)
//   found_o : at least one request bit set
//   idx_o   : winning index (0 when nothing is found)
module rr_priority_picker
  import bus_master_arbiter_pkg::*;
#(
  parameter int unsigned NumMasters = 4,
  parameter int unsigned IdxW       = idx_width(NumMasters)
) (
  input  logic [NumMasters-1:0] req_i,
  input  logic [IdxW-1:0]       last_i,
  output logic                  found_o,
  output logic [IdxW-1:0]       idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    // Offset 1..NumMasters visits every index once, ending on last_i itself.
    for (int unsigned off = 1; off <= NumMasters; off++) begin
      cand = IdxW'((32'(last_i) + off) % NumMasters);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter
// Shares the system bus among NUM_MASTERS external masters. A winner is picked
// round-robin in idle, the bus arbiter is asked to hold off the CPU
// (hold_request), and the grant is issued once the CPU side reports the bus
// released. The winner keeps the bus until it drops its request.
// Optional feature macro: BUS_MASTER_ARB_TIMEOUT_EN -- limits a grant to
// TIMEOUT_CYCLES cycles, pulses timeout_abort and locks the offender out until
// its request is seen low.
// Ports:
//   clock         : system clock
//   reset_n       : asynchronous active-low reset
//   request       : level request per master
//   bus_released  : CPU side has released the bus
//   hold_request  : external access request to the bus arbiter
//   grant         : one-hot bus ownership
//   grant_valid   : OR of grant
//   grant_index   : index of the current or last winner
//   timeout_abort : one-cycle pulse when a grant is revoked by timeout
module bus_master_arbiter
  import bus_master_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [NUM_MASTERS-1:0]               request,
  input  logic                                 bus_released,
  output logic                                 hold_request,
  output logic [NUM_MASTERS-1:0]               grant,
  output logic                                 grant_valid,
  output logic [idx_width(NUM_MASTERS)-1:0]    grant_index,
  output logic                                 timeout_abort
);

  localparam int unsigned IdxW = idx_width(NUM_MASTERS);
  localparam logic [IdxW-1:0] LastInit = IdxW'(NUM_MASTERS - 1);

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS) begin : gen_bad_num_masters
    $error("NUM_MASTERS must be within 2..MAX_MASTERS");
  end
  if (TIMEOUT_CYCLES < 2) begin : gen_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  arb_state_e             state_q, state_d;
  logic                   hold_q, hold_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [IdxW-1:0]        last_q, last_d;
  logic [NUM_MASTERS-1:0] eligible;
  logic                   pick_found;
  logic [IdxW-1:0]        pick_idx;

`ifdef BUS_MASTER_ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   abort_q, abort_d;
  logic                   timeout_hit;

  assign timeout_hit   = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
  assign eligible      = request & ~mask_q;
  assign timeout_abort = abort_q;
`else
  assign eligible      = request;
  assign timeout_abort = 1'b0;
`endif

  rr_priority_picker #(
    .NumMasters (NUM_MASTERS),
    .IdxW       (IdxW)
  ) u_picker (
    .req_i   (eligible),
    .last_i  (last_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
    abort_d = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          state_d = StRequest;
          idx_d   = pick_idx;
        end
      end
      StRequest: begin
        // A winner giving up before the bus is free aborts without a grant.
        if (!request[idx_q]) begin
          state_d = StRelease;
        end else if (bus_released) begin
          state_d = StGranted;
        end
      end
      StGranted: begin
        // Normal release and CPU-side protocol error both beat the timeout.
        if (!request[idx_q] || !bus_released) begin
          state_d = StRelease;
        end
`ifdef BUS_MASTER_ARB_TIMEOUT_EN
        else if (timeout_hit) begin
          state_d = StRelease;
          abort_d = 1'b1;
        end
`endif
      end
      StRelease: begin
        if (!bus_released) begin
          state_d = StIdle;
          last_d  = idx_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered copies of what the next state implies.
    hold_d        = (state_d == StRequest) || (state_d == StGranted);
    grant_valid_d = (state_d == StGranted);
    grant_d       = grant_valid_d ? (NUM_MASTERS'(1) << idx_d) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      hold_q        <= 1'b0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      idx_q         <= '0;
      last_q        <= LastInit;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
    end
  end

`ifdef BUS_MASTER_ARB_TIMEOUT_EN
  always_comb begin
    // Zero outside GRANTED, so the count starts at 0 on entry.
    cnt_d  = (state_q == StGranted) ? cnt_q + 1'b1 : '0;
    // A request seen low lifts that master's lockout.
    mask_d = mask_q & request;
    if (abort_d) begin
      mask_d[idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      mask_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      abort_q <= abort_d;
    end
  end
`endif

  assign hold_request = hold_q;
  assign grant        = grant_q;
  assign grant_valid  = grant_valid_q;
  assign grant_index  = idx_q;

endmodule

// File: tb/tb_bus_master_arbiter.sv
// tb_bus_master_arbiter
// Self-checking bench for bus_master_arbiter (4 masters, 16-cycle timeout when
// BUS_MASTER_ARB_TIMEOUT_EN is defined). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_bus_master_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic         clock        = 1'b0;
  logic         reset_n      = 1'b0;
  logic [N-1:0] request      = '0;
  logic         bus_released = 1'b0;
  logic         hold_request;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [1:0]   grant_index;
  logic         timeout_abort;

  int          checks   = 0;
  int          failures = 0;
  int unsigned model_last;

  bus_master_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .request       (request),
    .bus_released  (bus_released),
    .hold_request  (hold_request),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_index   (grant_index),
    .timeout_abort (timeout_abort)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  // Next winner: lowest requesting index above the last winner, else the
  // lowest requesting index overall.
  function automatic int unsigned rr_model(input logic [N-1:0] req, input int unsigned last);
    int unsigned lowest = N;
    int unsigned above  = N;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        if (lowest == N) lowest = i;
        if (above == N && i > last) above = i;
      end
    end
    return (above != N) ? above : lowest;
  endfunction

  task automatic do_reset;
    reset_n      = 1'b0;
    request      = '0;
    bus_released = 1'b0;
    repeat (2) @(negedge clock);
    reset_n    = 1'b1;
    model_last = N - 1;
  endtask

  task automatic wait_hold(output bit ok, output int lat);
    ok  = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (hold_request === 1'b1) begin
        ok  = 1'b1;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    request = 4'b0001;
    @(negedge clock);
    checks++;
    if ({hold_request, grant, grant_valid, grant_index, timeout_abort} !== 9'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b",
               {hold_request, grant, grant_valid, grant_index, timeout_abort}, 9'b0);
    end
    @(negedge clock);
    checks++;
    if (hold_request !== 1'b0) begin
      failures++;
      $display("FAIL reset_holds_off: hold_request=%b expected 0", hold_request);
    end
    request = '0;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if ({hold_request, grant_valid} !== 2'b00) begin
      failures++;
      $display("FAIL idle_no_request: hold/valid=%b expected 00", {hold_request, grant_valid});
    end
  endtask

  task automatic test_single;
    do_reset;
    request = 4'b0100;
    @(negedge clock);
    checks++;
    if ({hold_request, grant, grant_index} !== {1'b1, 4'b0000, 2'd2}) begin
      failures++;
      $display("FAIL single_hold: hold/grant/index=%b expected %b",
               {hold_request, grant, grant_index}, {1'b1, 4'b0000, 2'd2});
    end
    repeat (2) begin
      @(negedge clock);
      checks++;
      if ({hold_request, grant} !== 5'b1_0000) begin
        failures++;
        $display("FAIL single_wait: hold/grant=%b expected 10000", {hold_request, grant});
      end
    end
    bus_released = 1'b1;
    @(negedge clock);
    checks++;
    if ({grant, grant_valid, hold_request} !== {4'b0100, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL single_grant: grant/valid/hold=%b expected 010011",
               {grant, grant_valid, hold_request});
    end
    request = '0;
    @(negedge clock);
    checks++;
    if ({grant, grant_valid, hold_request, grant_index} !== {6'b0, 2'd2}) begin
      failures++;
      $display("FAIL single_release: grant/valid/hold/index=%b expected 00000010",
               {grant, grant_valid, hold_request, grant_index});
    end
    bus_released = 1'b0;
    model_last   = 2;
    @(negedge clock);
    request = 4'b0110;
    begin
      bit ok;
      int lat;
      wait_hold(ok, lat);
      checks++;
      if (!ok || grant_index !== 2'(rr_model(4'b0110, model_last))) begin
        failures++;
        $display("FAIL single_next_rr: ok=%0d index=%0d expected %0d", ok, grant_index,
                 rr_model(4'b0110, model_last));
      end
    end
  endtask

  task automatic test_fairness;
    int unsigned seq [5] = '{0, 1, 2, 3, 0};
    do_reset;
    @(negedge clock);
    request = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      bit ok;
      int lat;
      int unsigned exp;
      exp = rr_model(request, model_last);
      wait_hold(ok, lat);
      checks++;
      if (!ok || lat != ((k == 0) ? 1 : 2)) begin
        failures++;
        $display("FAIL fair_latency[%0d]: ok=%0d latency=%0d expected %0d", k, ok, lat,
                 (k == 0) ? 1 : 2);
      end
      checks++;
      if (grant_index !== 2'(exp) || grant_index !== 2'(seq[k])) begin
        failures++;
        $display("FAIL fair_index[%0d]: got %0d expected %0d", k, grant_index, seq[k]);
      end
      bus_released = 1'b1;
      @(negedge clock);
      checks++;
      if (grant !== (4'b0001 << exp)) begin
        failures++;
        $display("FAIL fair_grant[%0d]: got %b expected %b", k, grant, 4'b0001 << exp);
      end
      request[exp] = 1'b0;
      @(negedge clock);
      checks++;
      if ({grant, hold_request} !== 5'b0) begin
        failures++;
        $display("FAIL fair_release[%0d]: grant/hold=%b expected 00000", k, {grant, hold_request});
      end
      bus_released = 1'b0;
      request      = 4'b1111;
      model_last   = exp;
    end
  endtask

  task automatic test_abort;
    bit ok;
    int lat;
    do_reset;
    @(negedge clock);
    request = 4'b0010;
    wait_hold(ok, lat);
    checks++;
    if (!ok || grant_index !== 2'd1) begin
      failures++;
      $display("FAIL abort_hold: ok=%0d index=%0d expected 1", ok, grant_index);
    end
    @(negedge clock);
    checks++;
    if (grant !== 4'b0000) begin
      failures++;
      $display("FAIL abort_no_grant: got %b expected 0000", grant);
    end
    request = '0;
    @(negedge clock);
    checks++;
    if ({hold_request, grant, grant_valid} !== 6'b0) begin
      failures++;
      $display("FAIL abort_drop: hold/grant/valid=%b expected 000000",
               {hold_request, grant, grant_valid});
    end
    model_last = 1;
    request    = 4'b0011;
    wait_hold(ok, lat);
    checks++;
    if (!ok || grant_index !== 2'(rr_model(4'b0011, model_last))) begin
      failures++;
      $display("FAIL abort_last_winner: index=%0d expected %0d", grant_index,
               rr_model(4'b0011, model_last));
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int lat;
    do_reset;
    @(negedge clock);
    request = 4'b0001;
    wait_hold(ok, lat);
    bus_released = 1'b1;
    @(negedge clock);
    checks++;
    if (grant !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_grant: got %b expected 0001", grant);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({hold_request, grant, grant_valid, grant_index} !== 8'b0) begin
      failures++;
      $display("FAIL rstmid_async: hold/grant/valid/index=%b expected 00000000",
               {hold_request, grant, grant_valid, grant_index});
    end
    @(negedge clock);
    request      = 4'b1000;
    bus_released = 1'b0;
    reset_n      = 1'b1;
    model_last   = N - 1;
    wait_hold(ok, lat);
    checks++;
    if (!ok || grant_index !== 2'd3) begin
      failures++;
      $display("FAIL rstmid_first: ok=%0d index=%0d expected 3", ok, grant_index);
    end
    bus_released = 1'b1;
    @(negedge clock);
    checks++;
    if (grant !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_regrant: got %b expected 1000", grant);
    end
  endtask

  task automatic test_protocol;
    bit ok;
    int lat;
    do_reset;
    @(negedge clock);
    request = 4'b0100;
    wait_hold(ok, lat);
    bus_released = 1'b1;
    @(negedge clock);
    checks++;
    if (grant !== 4'b0100) begin
      failures++;
      $display("FAIL proto_grant: got %b expected 0100", grant);
    end
    bus_released = 1'b0;
    @(negedge clock);
    checks++;
    if ({hold_request, grant, grant_valid, timeout_abort} !== 7'b0) begin
      failures++;
      $display("FAIL proto_revoke: hold/grant/valid/abort=%b expected 0000000",
               {hold_request, grant, grant_valid, timeout_abort});
    end
    model_last = 2;
    wait_hold(ok, lat);
    checks++;
    if (!ok || lat != 2 || grant_index !== 2'(rr_model(request, model_last))) begin
      failures++;
      $display("FAIL proto_rearb: ok=%0d latency=%0d index=%0d expected latency 2 index %0d",
               ok, lat, grant_index, rr_model(request, model_last));
    end
  endtask

  task automatic test_random;
    do_reset;
    for (int iter = 0; iter < 40; iter++) begin
      bit ok;
      int lat;
      int unsigned exp;
      logic [N-1:0] wmask;
      @(negedge clock);
      request = N'($urandom_range(1, (1 << N) - 1));
      exp     = rr_model(request, model_last);
      wmask   = 4'b0001 << exp;
      wait_hold(ok, lat);
      checks++;
      if (!ok || lat != 1 || grant_index !== 2'(exp)) begin
        failures++;
        $display("FAIL rand_pick[%0d]: ok=%0d latency=%0d index=%0d expected index %0d req=%b",
                 iter, ok, lat, grant_index, exp, request);
      end
      repeat ($urandom_range(0, 3)) begin
        request = (N'($urandom) & ~wmask) | wmask;
        @(negedge clock);
        checks++;
        if ({hold_request, grant} !== 5'b1_0000) begin
          failures++;
          $display("FAIL rand_wait[%0d]: hold/grant=%b expected 10000", iter,
                   {hold_request, grant});
        end
      end
      bus_released = 1'b1;
      @(negedge clock);
      checks++;
      if ({grant, grant_valid, hold_request} !== {wmask, 2'b11}) begin
        failures++;
        $display("FAIL rand_grant[%0d]: grant/valid/hold=%b expected %b", iter,
                 {grant, grant_valid, hold_request}, {wmask, 2'b11});
      end
      repeat ($urandom_range(0, 3)) begin
        request = (N'($urandom) & ~wmask) | wmask;
        @(negedge clock);
        checks++;
        if (grant !== wmask) begin
          failures++;
          $display("FAIL rand_hold[%0d]: grant=%b expected %b", iter, grant, wmask);
        end
      end
      if ($urandom_range(0, 1) == 1) request[exp] = 1'b0;
      else bus_released = 1'b0;
      @(negedge clock);
      checks++;
      if ({hold_request, grant, grant_valid} !== 6'b0) begin
        failures++;
        $display("FAIL rand_release[%0d]: hold/grant/valid=%b expected 000000", iter,
                 {hold_request, grant, grant_valid});
      end
      bus_released = 1'b0;
      model_last   = exp;
    end
  endtask

`ifdef BUS_MASTER_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int lat;
    int cnt;
    bit held_off;
    do_reset;
    @(negedge clock);
    request = 4'b0100;
    wait_hold(ok, lat);
    bus_released = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (grant === 4'b0100) cnt++;
      else break;
    end
    checks++;
    if (cnt != TO) begin
      failures++;
      $display("FAIL timeout_length: grant cycles=%0d expected %0d", cnt, TO);
    end
    checks++;
    if ({timeout_abort, hold_request} !== 2'b10) begin
      failures++;
      $display("FAIL timeout_pulse: abort/hold=%b expected 10", {timeout_abort, hold_request});
    end
    @(negedge clock);
    checks++;
    if (timeout_abort !== 1'b0) begin
      failures++;
      $display("FAIL timeout_pulse_width: abort=%b expected 0", timeout_abort);
    end
    bus_released = 1'b0;
    held_off     = 1'b1;
    repeat (6) begin
      @(negedge clock);
      if (hold_request !== 1'b0) held_off = 1'b0;
    end
    checks++;
    if (!held_off) begin
      failures++;
      $display("FAIL timeout_lockout: masked master re-requested, expected hold 0");
    end
    request = '0;
    @(negedge clock);
    request = 4'b0100;
    wait_hold(ok, lat);
    checks++;
    if (!ok || lat != 1 || grant_index !== 2'd2) begin
      failures++;
      $display("FAIL timeout_unmask: ok=%0d latency=%0d index=%0d expected 1/2", ok, lat,
               grant_index);
    end
  endtask
`else
  task automatic test_timeout;
    bit ok;
    int lat;
    bit stable;
    do_reset;
    @(negedge clock);
    request = 4'b0100;
    wait_hold(ok, lat);
    bus_released = 1'b1;
    stable = 1'b1;
    repeat (3 * TO) begin
      @(negedge clock);
      if (grant !== 4'b0100 || timeout_abort !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL no_timeout: grant=%b abort=%b expected grant 0100 abort 0 throughout",
               grant, timeout_abort);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_abort;
    test_reset_mid;
    test_protocol;
    test_timeout;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
